ser_rx_deser: RTL and testbench
===============================

Name: ser_rx_deser

Overview:
- Serial-to-parallel frame receiver. It is the receiving end of the team's universal shift register when that register is used as a parallel-to-serial transmitter.
- Frame format: start bit (0), WIDTH data bits, optional parity bit, stop bit (1).
- Bit order is selectable: LSB-first (right-shift fill) or MSB-first (left-shift fill).
- Bit timing comes from an external bit_tick strobe. Completed words go out on a valid/ready register interface with framing and overrun error reporting.

Parameters:
- WIDTH, 4, data bits per frame. Legal range 2..16.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rstn  input  1  reset, asynchronous, active-low.
- bit_tick  input  1  one-cycle strobe at each bit's mid-sample point. ser_in is sampled only when bit_tick=1.
- ser_in  input  1  serial line; idles high.
- lsb_first  input  1  1 = first data bit is the LSB; 0 = first data bit is the MSB.
- rx_ready  input  1  consumer accepts rx_data when rx_valid=1.
- err_clr  input  1  one-cycle pulse; clears overrun.
- rx_data  output  WIDTH  received word, registered.
- rx_valid  output  1  rx_data holds an unconsumed word.
- frame_err  output  1  one-cycle pulse: bad stop bit (or bad parity, see Optional Feature).
- overrun  output  1  sticky: a completed word was dropped.
- busy  output  1  1 whenever the FSM is not in IDLE.

Behaviour:
- Reset (async, rstn=0): state=IDLE, shift reg=0, bit counter=0, rx_data=0, rx_valid=0, frame_err=0, overrun=0, busy=0.
- IDLE:
  - On bit_tick with ser_in=0 (start bit): go to DATA, clear counter, latch lsb_first into an internal frame register.
  - lsb_first changes mid-frame are ignored.
  - bit_tick with ser_in=1: stay in IDLE.
- DATA, on each bit_tick:
  - lsb_first latched 1: shreg <= {ser_in, shreg[WIDTH-1:1]}.
  - lsb_first latched 0: shreg <= {shreg[WIDTH-2:0], ser_in}.
  - Counter increments. The tick that captures bit WIDTH-1 moves to STOP (or PARITY if enabled).
- Cycles without bit_tick: no state, counter or shreg change in any state.
- STOP, on bit_tick:
  - ser_in=1 (good stop): deliver the word (see Delivery), then go to IDLE.
  - ser_in=0: pulse frame_err=1 for exactly one cycle, discard the word, go to IDLE. A low stop bit is NOT treated as a new start bit.
- Delivery, registered; rx_data/rx_valid update on the clock edge of the stop-bit tick:
  - rx_valid=0, or rx_valid=1 and rx_ready=1 that cycle: rx_data <= shreg, rx_valid <= 1.
  - rx_valid=1 and rx_ready=0: new word dropped, rx_data unchanged, overrun <= 1.
- Consume: rx_valid=1 and rx_ready=1 with no delivery that cycle → rx_valid <= 0; rx_data holds its last value.
- overrun clears on err_clr=1. If err_clr and a new overrun event occur in the same cycle, the set wins.
- busy = (state != IDLE). A new start bit can be accepted on the first tick after returning to IDLE.
- Reset mid-frame: frame is aborted immediately, all outputs return to reset values, and any held rx_data word is lost.

Optional Feature:
- Macro: SER_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP. One extra bit is sampled on its bit_tick.
  - Even parity: the XOR of the WIDTH data bits and the parity bit must be 0.
  - Parity mismatch: the frame continues to STOP. At the STOP tick, frame_err pulses and the word is discarded, regardless of the stop bit value.
- Undefined: no PARITY state. Frame length is WIDTH+2 ticks.

Test Plan:
- Reset/idle: rstn low mid-operation, then release with ser_in=1 and 10 bit_ticks → all outputs 0, busy=0.
- LSB-first, WIDTH=4, lsb_first=1, ticks carry 0,1,1,0,1,1 (start, data 1,1,0,1, stop) → rx_data=4'hB and rx_valid=1 one cycle after the stop tick. Hold rx_ready=1 one cycle → rx_valid=0.
- MSB-first, lsb_first=0, ticks carry 0,1,0,1,1,1 → rx_data=4'hB. Toggling lsb_first mid-frame does not change the result.
- Framing error: ticks carry 0,1,1,1,1,0 → frame_err high exactly 1 cycle, rx_valid stays 0, next good frame 0,0,0,1,1,1 with lsb_first=1 → rx_data=4'hC.
- Overrun: two good frames 4'h3 then 4'h5 with rx_ready=0 → rx_data=4'h3 and overrun=1. err_clr pulse → overrun=0. Consume and deliver in the same cycle → new word loaded, overrun stays 0.
- With SER_RX_PARITY_EN: frame with data 4'hB and parity bit 1 → accepted. Same frame with parity bit 0 → frame_err pulse, no rx_valid.

Source files
------------

// File: rtl/ser_rx_deser.sv
// ser_rx_deser: serial-to-parallel frame receiver.
// Frame: start (0), WIDTH data bits (LSB- or MSB-first), optional even
// parity bit, stop (1). Bits are sampled only on the external bit_tick
// strobe. Completed words are presented on a registered valid/ready
// interface. frame_err is a one-cycle pulse and overrun is a sticky flag.
// Optional feature macro: SER_RX_PARITY_EN (adds an even-parity bit
// between the data bits and the stop bit).

module ser_rx_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             bit_tick,
  input  logic             ser_in,
  input  logic             lsb_first,
  input  logic             rx_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // S_PARITY is only reachable when the parity feature is compiled in.
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DATA   = 2'd1,
    S_PARITY = 2'd2,
    S_STOP   = 2'd3
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lsb_q, lsb_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             par_err_q, par_err_d;

  // Control strobes decoded from the current state and the bit tick.
  logic start_ev;
  logic shift_en;
  logic par_en;
  logic stop_ev;
  logic word_ok;
  logic load;
  logic drop;
  logic consume;

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the FSM only advances on bit_tick.
  always_comb begin
    state_d = state_q;
    if (bit_tick) begin
      unique case (state_q)
        S_IDLE: begin
          if (!ser_in) state_d = S_DATA;
        end
        S_DATA: begin
          if (cnt_q == LAST_BIT) begin
`ifdef SER_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end
        end
        S_PARITY: state_d = S_STOP;
        S_STOP:   state_d = S_IDLE; // a low stop bit never re-arms a start
        default:  state_d = S_IDLE;
      endcase
    end
  end

  // Output decode: per-cycle strobes that steer the datapath.
  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    start_ev = bit_tick && (state_q == S_IDLE) && !ser_in;
    shift_en = bit_tick && (state_q == S_DATA);
    par_en   = bit_tick && (state_q == S_PARITY);
    stop_ev  = bit_tick && (state_q == S_STOP);
    word_ok  = ser_in && !par_err_q;
    load     = 1'b0;
    drop     = 1'b0;
    consume  = 1'b0;
    if (stop_ev && word_ok) begin
      if (!rx_valid_q || rx_ready) load = 1'b1;
      else                         drop = 1'b1;
    end else if (rx_valid_q && rx_ready) begin
      consume = 1'b1;
    end
    busy = (state_q != S_IDLE);
  end

  // Datapath next-state: counter, shift register, delivery and error flags.
  always_comb begin
    cnt_d       = cnt_q;
    lsb_d       = lsb_q;
    shreg_d     = shreg_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    frame_err_d = stop_ev && !word_ok;
    overrun_d   = overrun_q;
    par_err_d   = par_err_q;

    // Bit order is frozen at the start bit; later lsb_first edges are ignored.
    if (start_ev) begin
      cnt_d = '0;
      lsb_d = lsb_first;
    end

    if (shift_en) begin
      if (lsb_q) shreg_d = {ser_in, shreg_q[WIDTH-1:1]};
      else       shreg_d = {shreg_q[WIDTH-2:0], ser_in};
      cnt_d = cnt_q + 1'b1;
    end

`ifdef SER_RX_PARITY_EN
    // Even parity over the data bits and the parity bit; the verdict is held
    // until the stop tick so the frame still finishes on time.
    if (start_ev) par_err_d = 1'b0;
    if (par_en)   par_err_d = (^shreg_q) ^ ser_in;
`else
    par_err_d = 1'b0;
`endif

    if (load) begin
      rx_data_d  = shreg_q;
      rx_valid_d = 1'b1;
    end else if (consume) begin
      rx_valid_d = 1'b0;
    end

    // A fresh overrun beats a simultaneous clear.
    if (drop)         overrun_d = 1'b1;
    else if (err_clr) overrun_d = 1'b0;
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      cnt_q       <= '0;
      lsb_q       <= 1'b0;
      shreg_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      par_err_q   <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      lsb_q       <= lsb_d;
      shreg_q     <= shreg_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      par_err_q   <= par_err_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ser_rx_deser.sv
// tb_ser_rx_deser: self-checking bench for ser_rx_deser.
// Frames are built from a word, a bit order and error choices; the reference
// model knows only the word and whether the frame was good, and tracks the
// valid/ready hand-off and overrun flag at transaction level.

module tb_ser_rx_deser;

  localparam int W = 4;

  typedef enum int {EV_NONE, EV_GOOD, EV_BAD} ev_e;

  logic         clk = 1'b0;
  logic         rstn;
  logic         bit_tick;
  logic         ser_in;
  logic         lsb_first;
  logic         rx_ready;
  logic         err_clr;
  logic [W-1:0] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic         overrun;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [W-1:0] m_data;
  bit           m_valid;
  bit           m_ovr;
  bit           m_busy;

  // Stimulus knobs.
  bit rand_rdy   = 1'b0;
  bit toggle_lsb = 1'b0;

  ser_rx_deser #(.WIDTH(W)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .bit_tick  (bit_tick),
    .ser_in    (ser_in),
    .lsb_first (lsb_first),
    .rx_ready  (rx_ready),
    .err_clr   (err_clr),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs(input bit exp_ferr);
    check("rx_valid", {31'd0, rx_valid}, {31'd0, m_valid});
    check("rx_data", {{(32-W){1'b0}}, rx_data}, {{(32-W){1'b0}}, m_data});
    check("frame_err", {31'd0, frame_err}, {31'd0, exp_ferr});
    check("overrun", {31'd0, overrun}, {31'd0, m_ovr});
    check("busy", {31'd0, busy}, {31'd0, m_busy});
  endtask

  // One clock cycle: drive inputs, advance the model on the edge, check #1 later.
  task automatic cyc(input logic bt, input logic si, input ev_e ev,
                     input logic [W-1:0] word, input bit busy_after,
                     input bit is_start, input bit lsb);
    bit ovf;
    if (rand_rdy) begin
      rx_ready = ($urandom_range(0, 2) == 0);
      err_clr  = ($urandom_range(0, 15) == 0);
    end
    if (is_start)        lsb_first = lsb;
    else if (toggle_lsb) lsb_first = $urandom_range(0, 1) == 1;
    bit_tick = bt;
    ser_in   = si;
    @(posedge clk);
    ovf = 1'b0;
    if (ev == EV_GOOD) begin
      if (!m_valid || rx_ready) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        ovf = 1'b1;
      end
    end else if (m_valid && rx_ready) begin
      m_valid = 1'b0;
    end
    if (ovf)          m_ovr = 1'b1;
    else if (err_clr) m_ovr = 1'b0;
    m_busy = busy_after;
    #1;
    check_outputs(ev == EV_BAD);
  endtask

  task automatic gap(input int max_gap);
    int n;
    n = $urandom_range(0, max_gap);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'($urandom_range(0, 1)), EV_NONE, '0, m_busy, 1'b0, 1'b0);
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, EV_NONE, '0, 1'b0, 1'b0, 1'b0);
  endtask

  // Sends one frame; stop_rdy raises rx_ready only for the stop tick.
  task automatic send_frame(input logic [W-1:0] word, input bit lsb, input bit par_bad,
                            input bit stop_bit, input int max_gap, input bit stop_rdy);
    ev_e last;
    logic b;
    bit pb;
`ifdef SER_RX_PARITY_EN
    pb = par_bad;
`else
    pb = 1'b0;
`endif
    last = (stop_bit && !pb) ? EV_GOOD : EV_BAD;
    gap(max_gap);
    cyc(1'b1, 1'b0, EV_NONE, '0, 1'b1, 1'b1, lsb);
    for (int i = 0; i < W; i++) begin
      gap(max_gap);
      b = lsb ? word[i] : word[W-1-i];
      cyc(1'b1, b, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
    end
`ifdef SER_RX_PARITY_EN
    gap(max_gap);
    cyc(1'b1, (^word) ^ pb, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
`endif
    gap(max_gap);
    if (stop_rdy) rx_ready = 1'b1;
    cyc(1'b1, stop_bit, last, word, 1'b0, 1'b0, 1'b0);
    if (stop_rdy) rx_ready = 1'b0;
  endtask

  task automatic consume_one();
    rx_ready = 1'b1;
    cyc(1'b0, 1'b1, EV_NONE, '0, m_busy, 1'b0, 1'b0);
    rx_ready = 1'b0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    bit_tick = 1'b0;
    #1;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_busy  = 1'b0;
    check_outputs(1'b0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn      = 1'b0;
    bit_tick  = 1'b0;
    ser_in    = 1'b1;
    lsb_first = 1'b1;
    rx_ready  = 1'b0;
    err_clr   = 1'b0;
    m_data    = '0;
    m_valid   = 1'b0;
    m_ovr     = 1'b0;
    m_busy    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0);
    @(negedge clk);
    rstn = 1'b1;
    idle_ticks(3);

    // LSB-first 0,1,1,0,1,1 -> 4'hB, then consume.
    send_frame(4'hB, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("lsb_word", {28'd0, rx_data}, 32'hB);
    check("lsb_valid", {31'd0, rx_valid}, 32'd1);
    consume_one();

    // MSB-first 0,1,0,1,1,1 with lsb_first toggling mid-frame -> 4'hB.
    toggle_lsb = 1'b1;
    send_frame(4'hB, 1'b0, 1'b0, 1'b1, 2, 1'b0);
    toggle_lsb = 1'b0;
    check("msb_word", {28'd0, rx_data}, 32'hB);
    consume_one();

    // Framing error, low stop must not start a frame, then good 4'hC.
    send_frame(4'hF, 1'b1, 1'b0, 1'b0, 0, 1'b0);
    idle_ticks(2);
    send_frame(4'hC, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("after_ferr_word", {28'd0, rx_data}, 32'hC);
    consume_one();

    // Overrun: 3 then 5 unconsumed, clear, then deliver-while-consume.
    send_frame(4'h3, 1'b1, 1'b0, 1'b1, 1, 1'b0);
    send_frame(4'h5, 1'b0, 1'b0, 1'b1, 0, 1'b0);
    check("ovr_word_kept", {28'd0, rx_data}, 32'h3);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    err_clr = 1'b1;
    cyc(1'b0, 1'b1, EV_NONE, '0, 1'b0, 1'b0, 1'b0);
    err_clr = 1'b0;
    check("ovr_cleared", {31'd0, overrun}, 32'd0);
    send_frame(4'h6, 1'b1, 1'b0, 1'b1, 0, 1'b1);
    check("swap_word", {28'd0, rx_data}, 32'h6);
    check("swap_no_ovr", {31'd0, overrun}, 32'd0);
    // Overrun set beats err_clr held through the stop tick.
    err_clr = 1'b1;
    send_frame(4'h9, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    err_clr = 1'b0;
    check("set_beats_clr", {31'd0, overrun}, 32'd1);
    check("set_beats_clr_word", {28'd0, rx_data}, 32'h6);
    consume_one();

`ifdef SER_RX_PARITY_EN
    send_frame(4'hB, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("par_ok_word", {28'd0, rx_data}, 32'hB);
    consume_one();
    send_frame(4'hB, 1'b1, 1'b1, 1'b1, 0, 1'b0);
    check("par_bad_valid", {31'd0, rx_valid}, 32'd0);
`endif

    // Reset mid-frame drops held word and aborts the frame.
    send_frame(4'hA, 1'b1, 1'b0, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b0, EV_NONE, '0, 1'b1, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, EV_NONE, '0, 1'b1, 1'b0, 1'b0);
    do_reset();
    idle_ticks(10);
    check("post_reset_data", {28'd0, rx_data}, 32'h0);

    // Randomized frames with random ready, clear and lsb_first noise.
    rand_rdy   = 1'b1;
    toggle_lsb = 1'b1;
    for (int f = 0; f < 60; f++) begin
      send_frame(W'($urandom_range(0, (1 << W) - 1)), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) != 0, 3, 1'b0);
      if ($urandom_range(0, 3) == 0) idle_ticks($urandom_range(1, 2));
    end
    rand_rdy   = 1'b0;
    toggle_lsb = 1'b0;
    rx_ready   = 1'b0;
    err_clr    = 1'b0;
    idle_ticks(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
